// File: rtl/param_seq_datapath.sv
// Parametrised datapath with a valid/ready command port and an internal sequencer.
// Each command fetches A and B, executes, and writes back over a fixed 4-cycle pipeline.
module param_seq_datapath #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int RA_W   = 3,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_aluop,
    input  logic [1:0]        cmd_shift,
    input  logic [RA_W-1:0]   cmd_rn,
    input  logic [RA_W-1:0]   cmd_rm,
    input  logic [RA_W-1:0]   cmd_rd,
    input  logic              cmd_asel,
    input  logic              cmd_bsel,
    input  logic [1:0]        cmd_wsel,
    input  logic              cmd_wen,
    input  logic              cmd_sets,
    input  logic [DATA_W-1:0] sximm5,
    input  logic [DATA_W-1:0] sximm8,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] mdata,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        status,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] a_q, b_q, result_q;
    logic [2:0]        status_q;
    logic              done_q;

    logic [1:0]        aluop_q, shift_q, wsel_q;
    logic [RA_W-1:0]   rn_q, rm_q, rd_q;
    logic              asel_q, bsel_q, wen_q, sets_q;
    logic [DATA_W-1:0] imm5_q, imm8_q;
    logic [PC_W-1:0]   pc_q;

    logic [DATA_W-1:0] shifted, ain, bin, result_d, wbData;
    logic [2:0]        status_d;
    logic              ovf;

    assign cmd_ready = (state_q == IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign status    = status_q;
    assign dbg_data  = regs_q[dbg_addr];

    always_comb begin
        case (shift_q)
            2'b01:   shifted = {b_q[MSB-1:0], 1'b0};
            2'b10:   shifted = {1'b0, b_q[MSB:1]};
            2'b11:   shifted = {b_q[MSB], b_q[MSB:1]};
            default: shifted = b_q;
        endcase
        ain = asel_q ? '0 : a_q;
        bin = bsel_q ? imm5_q : shifted;
        ovf = 1'b0;
        // Overflow is judged from operand and result sign bits; carry out is discarded.
        case (aluop_q)
            2'b00: begin
                result_d = ain + bin;
                ovf      = (ain[MSB] == bin[MSB]) && (result_d[MSB] != ain[MSB]);
            end
            2'b01: begin
                result_d = ain - bin;
                ovf      = (ain[MSB] != bin[MSB]) && (result_d[MSB] != ain[MSB]);
            end
            2'b10:   result_d = ain & bin;
            default: result_d = ~bin;
        endcase
        status_d = {ovf, result_d[MSB], result_d == '0};
        case (wsel_q)
            2'b00:   wbData = result_q;
            2'b01:   wbData = mdata;
            2'b10:   wbData = imm8_q;
            default: wbData = DATA_W'(pc_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            regs_q   <= '{default: '0};
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            status_q <= 3'b000;
            done_q   <= 1'b0;
            aluop_q  <= '0;
            shift_q  <= '0;
            wsel_q   <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            wen_q    <= 1'b0;
            sets_q   <= 1'b0;
            imm5_q   <= '0;
            imm8_q   <= '0;
            pc_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        aluop_q <= cmd_aluop;
                        shift_q <= cmd_shift;
                        wsel_q  <= cmd_wsel;
                        rn_q    <= cmd_rn;
                        rm_q    <= cmd_rm;
                        rd_q    <= cmd_rd;
                        asel_q  <= cmd_asel;
                        bsel_q  <= cmd_bsel;
                        wen_q   <= cmd_wen;
                        sets_q  <= cmd_sets;
                        imm5_q  <= sximm5;
                        imm8_q  <= sximm8;
                        pc_q    <= pc;
                        state_q <= RD_A;
                    end
                end
                RD_A: begin
                    a_q     <= regs_q[rn_q];
                    state_q <= RD_B;
                end
                RD_B: begin
                    b_q     <= regs_q[rm_q];
                    state_q <= EXEC;
                end
                EXEC: begin
                    result_q <= result_d;
                    if (sets_q) status_q <= status_d;
                    done_q   <= 1'b1;
                    state_q  <= WB;
                end
                WB: begin
                    if (wen_q) regs_q[rd_q] <= wbData;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
